bus_rr_scheduler: RTL
=====================

Name: bus_rr_scheduler

Overview:
- Round-robin master scheduler for the SoC bus switch.
- Arbitrates among up to N bus masters: graphics devices D0-D3 and the testbench master.
- Offers one grant at a time to the switch, then holds off all new grants until the switch reports that the transaction (single or 16-beat burst) has finished.
- A watchdog recovers the bus if a slave never completes a transaction.

Parameters:
N, 5, number of requesting masters (index 0-3 = D0-D3, 4 = testbench)
ID_W, 3, width of grant index; must satisfy 2**ID_W >= N
TIMEOUT, 256, max cycles from grant acceptance to xfer_done before abort (>= 2)
TMR_W, 16, watchdog counter width; must satisfy 2**TMR_W > TIMEOUT

Ports:
clk  input  1  bus clock, all state on rising edge
reset  input  1  reset, asynchronous, active-high
req  input  N  per-master request level, bit i = master i
req_en  input  N  per-master enable mask; a request counts only when req[i] & req_en[i]
gnt_valid  output  1  grant offer valid
gnt_id  output  ID_W  index of offered/active master
gnt_onehot  output  N  one-hot of gnt_id, qualified by gnt_valid or busy
gnt_accept  input  1  switch latched the offer (single-cycle pulse)
xfer_done  input  1  switch finished the transaction, incl. last burst beat (single-cycle pulse)
busy  output  1  transaction in flight
timeout  output  1  single-cycle pulse: watchdog abort
rr_ptr  output  ID_W  current highest-priority index (debug)

Behaviour:
- Reset (async, immediate): state=IDLE; gnt_valid=0; gnt_id=0; gnt_onehot=0; busy=0; timeout=0; rr_ptr=0; timer=0.
- Effective request: eff = req & req_en.
- Winner: first set bit of eff scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N (not modulo 2**ID_W).
- States: IDLE, OFFER, BUSY. All outputs are registered.
- IDLE:
  - If eff != 0: latch winner into gnt_id, set gnt_valid=1, go OFFER.
  - Latency: request seen at edge k gives gnt_valid high after edge k+1.
  - If eff == 0: stay; outputs stay 0.
- OFFER:
  - gnt_valid and gnt_id stay stable until the offer resolves.
  - gnt_accept=1: gnt_valid=0, busy=1, rr_ptr = (gnt_id+1) mod N, timer=0, go BUSY.
  - eff[gnt_id]=0 and no accept (withdraw): gnt_valid=0, go IDLE, rr_ptr unchanged.
  - Accept and withdraw in the same cycle: accept wins.
  - Changes on other req bits are ignored.
- BUSY:
  - gnt_id holds; gnt_onehot holds.
  - Timer increments each cycle, saturating at TIMEOUT-1.
  - xfer_done=1: busy=0, go IDLE. No back-to-back grant in the same cycle; the next arbitration happens in IDLE on the following edge.
  - Timer == TIMEOUT-1 and no xfer_done: timeout=1 for one cycle, busy=0, go IDLE. rr_ptr keeps its advanced value, so the hung master loses priority.
  - xfer_done on the timeout cycle: done wins, no timeout pulse.
- Protocol errors are ignored with no state change:
  - gnt_accept outside OFFER.
  - xfer_done outside BUSY.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0; any requester waits at most N-1 transactions.
- Reset mid-OFFER or mid-BUSY: immediate return to reset values; no timeout pulse.

Test Plan:
- Reset, then req=5'b00001 → gnt_valid high on 2nd edge with gnt_id=0. Accept → busy=1, rr_ptr=1. xfer_done → busy=0.
- req=5'b11111 held, accept after 1 cycle and done after 3 cycles each time → grant order 0,1,2,3,4,0; gnt_onehot matches each grant.
- rr_ptr=3, req=5'b00101 → gnt_id=0 (wrap past 4 to 0, skipping unrequested 3/4); rr_ptr becomes 1.
- OFFER to id 2, drop req[2] with no accept → gnt_valid=0 next edge, rr_ptr unchanged. Simultaneous accept and drop → BUSY.
- TIMEOUT=8, accept with no xfer_done → timeout pulses exactly 8 cycles after accept, busy falls. Repeat with xfer_done on cycle 8 → no pulse.
- req_en=5'b11011 with req=5'b00100 → no grant. Assert reset during BUSY → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bus_rr_scheduler.sv
// Round-robin master scheduler for the SoC bus switch: one grant offer at a time,
// held until the transaction completes or the watchdog aborts it.
module bus_rr_scheduler #(
  parameter int N       = 5,
  parameter int ID_W    = 3,
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_en,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    gnt_onehot,
  input  logic            gnt_accept,
  input  logic            xfer_done,
  output logic            busy,
  output logic            timeout,
  output logic [ID_W-1:0] rr_ptr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [ID_W:0]    N_EXT    = (ID_W+1)'(N);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Increment modulo N, not modulo 2**ID_W.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    logic [ID_W:0] s;
    s = {1'b0, v} + (ID_W+1)'(1);
    if (s >= N_EXT) s = '0;
    return s[ID_W-1:0];
  endfunction

  function automatic logic [N-1:0] onehot_of(input logic [ID_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  logic [1:0]       state_q,      state_d;
  logic             gnt_valid_q,  gnt_valid_d;
  logic [ID_W-1:0]  gnt_id_q,     gnt_id_d;
  logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
  logic             busy_q,       busy_d;
  logic             timeout_q,    timeout_d;
  logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;
  logic [TMR_W-1:0] timer_q,      timer_d;

  logic [N-1:0]    eff;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] scan_idx;
  logic            win_found;

  assign eff = req & req_en;

  // Scan from the priority pointer, wrapping at N, and keep the first hit.
  always_comb begin
    win       = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && eff[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        // Accept beats a same-cycle withdraw.
        if (gnt_accept) begin
          gnt_valid_d = 1'b0;
          busy_d      = 1'b1;
          rr_ptr_d    = wrap_inc(gnt_id_q);
          timer_d     = '0;
          state_d     = S_BUSY;
        end else if (!eff[gnt_id_q]) begin
          gnt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_BUSY: begin
        if (xfer_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          // Pointer was already advanced at accept, so the hung master loses priority.
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    gnt_onehot_d = (gnt_valid_d || busy_d) ? onehot_of(gnt_id_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      gnt_onehot_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rr_ptr_q     <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_id_q     <= gnt_id_d;
      gnt_onehot_q <= gnt_onehot_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      rr_ptr_q     <= rr_ptr_d;
      timer_q      <= timer_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_onehot = gnt_onehot_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign rr_ptr     = rr_ptr_q;

endmodule
